// File: rtl/uart_apb_service_ctrl_if.sv
// APB signal bundle between the UART service controller (master) and the UART
// register slave; the controller is the only master on this bus.
interface uart_apb_service_ctrl_if #(
   parameter int unsigned PADDR_WIDTH = 8,
   parameter int unsigned PDATA_WIDTH = 8
);
   logic                   PSEL;
   logic                   PENABLE;
   logic                   PWRITE;
   logic [PADDR_WIDTH-1:0] PADDR;
   logic [PDATA_WIDTH-1:0] PWDATA;
   logic [PDATA_WIDTH-1:0] PRDATA;
   logic                   PREADY;
   logic                   PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/uart_apb_service_ctrl.sv
// APB master for the UART register port: runs the programming sequence on request, then
// arbitrates the port between IIR-driven interrupt servicing and host THR writes.
module uart_apb_service_ctrl #(
   parameter int unsigned PADDR_WIDTH = 8,
   parameter int unsigned PDATA_WIDTH = 8
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   uart_apb_service_ctrl_if.master apb,
   input  logic                    INTR,
   input  logic                    cfg_start,
   input  logic [15:0]             cfg_divisor,
   input  logic [5:0]              cfg_lcr,
   input  logic [7:0]              cfg_fcr,
   input  logic [4:0]              cfg_mcr,
   input  logic [3:0]              cfg_ier,
   output logic                    cfg_busy,
   output logic                    cfg_done,
   output logic                    cfg_err,
   output logic                    configured,
   input  logic                    tx_valid,
   input  logic [7:0]              tx_data,
   output logic                    tx_ready,
   output logic                    rx_valid,
   output logic [7:0]              rx_data,
   input  logic                    rx_ready,
   output logic                    lsr_valid,
   output logic [7:0]              lsr_data,
   output logic                    msr_valid,
   output logic [7:0]              msr_data,
   output logic                    thre_event,
   output logic                    slverr_sticky
);
   localparam logic [1:0] S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2, S_GAP = 2'd3;
   localparam logic [2:0] OP_CFG = 3'd0, OP_IIR = 3'd1, OP_LSR = 3'd2, OP_RBR = 3'd3,
                          OP_MSR = 3'd4, OP_TX = 3'd5;

   logic [1:0]  state_q, state_d;
   logic [2:0]  op_q, op_d, step_q, step_d, addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        write_q, write_d;
   logic [15:0] div_q, div_d;
   logic [5:0]  lcr_q, lcr_d;
   logic [7:0]  fcr_q, fcr_d;
   logic [4:0]  mcr_q, mcr_d;
   logic [3:0]  ier_q, ier_d;
   logic        busy_q, busy_d, done_q, done_d, err_q, err_d, cfgd_q, cfgd_d;
   logic        txr_q, txr_d, rxv_q, rxv_d, lsrv_q, lsrv_d, msrv_q, msrv_d;
   logic        thre_q, thre_d, slverr_q, slverr_d;
   logic [7:0]  rxd_q, rxd_d, lsrd_q, lsrd_d, msrd_q, msrd_d;
   logic [10:0] cfg_word;  // {addr, data} of configuration write number step_q
   logic [2:0]  rd_addr;
   logic [7:0]  rdata;

   assign rdata = apb.PRDATA[7:0];

   always_comb begin
      case (step_q)
         3'd0:    cfg_word = {3'd3, 2'b10, lcr_q};  // DLAB=1 opens DLL/DLM
         3'd1:    cfg_word = {3'd0, div_q[7:0]};
         3'd2:    cfg_word = {3'd1, div_q[15:8]};
         3'd3:    cfg_word = {3'd3, 2'b00, lcr_q};
         3'd4:    cfg_word = {3'd2, fcr_q};
         3'd5:    cfg_word = {3'd4, 3'b000, mcr_q};
         default: cfg_word = {3'd1, 4'b0000, ier_q};
      endcase
   end

   always_comb begin
      case (op_q)
         OP_LSR:  rd_addr = 3'd5;
         OP_MSR:  rd_addr = 3'd6;
         default: rd_addr = 3'd0;
      endcase
   end

   always_comb begin
      state_d = state_q;   op_d = op_q;       step_d = step_q;   addr_d = addr_q;
      wdata_d = wdata_q;   write_d = write_q; div_d = div_q;     lcr_d = lcr_q;
      fcr_d = fcr_q;       mcr_d = mcr_q;     ier_d = ier_q;     busy_d = busy_q;
      cfgd_d = cfgd_q;     rxv_d = rxv_q;     rxd_d = rxd_q;     lsrd_d = lsrd_q;
      msrd_d = msrd_q;     slverr_d = slverr_q;
      done_d = 1'b0;  err_d = 1'b0;  txr_d = 1'b0;  lsrv_d = 1'b0;  msrv_d = 1'b0;
      thre_d = 1'b0;
      if (rxv_q && rx_ready) rxv_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cfg_start) begin
               if (cfg_divisor == 16'd0) begin
                  err_d = 1'b1;
               end else begin
                  div_d = cfg_divisor;  lcr_d = cfg_lcr;  fcr_d = cfg_fcr;
                  mcr_d = cfg_mcr;      ier_d = cfg_ier;  busy_d = 1'b1;
                  op_d = OP_CFG;  step_d = 3'd0;  addr_d = 3'd3;
                  wdata_d = {2'b10, cfg_lcr};  write_d = 1'b1;  state_d = S_SETUP;
               end
            end else if (INTR && cfgd_q) begin
               op_d = OP_IIR;  addr_d = 3'd2;  wdata_d = 8'h00;  write_d = 1'b0;
               state_d = S_SETUP;
            end else if (tx_valid && cfgd_q) begin
               op_d = OP_TX;  addr_d = 3'd0;  wdata_d = tx_data;  write_d = 1'b1;
               state_d = S_SETUP;
            end
         end
         S_SETUP: state_d = S_ACCESS;
         S_ACCESS: begin
            if (apb.PREADY) begin
               if (apb.PSLVERR) slverr_d = 1'b1;
               state_d = S_IDLE;
               case (op_q)
                  OP_CFG: begin
                     if (step_q == 3'd6) begin
                        done_d = 1'b1;  busy_d = 1'b0;  cfgd_d = 1'b1;
                     end else begin
                        step_d = step_q + 3'd1;  state_d = S_GAP;
                     end
                  end
                  OP_IIR: begin
                     if (!rdata[0]) begin
                        case (rdata[3:1])
                           3'b011: begin op_d = OP_LSR; state_d = S_GAP; end
                           3'b010, 3'b110: begin
                              // Leave the byte in the FIFO until the consumer drains rx_data.
                              if (!rxv_q) begin op_d = OP_RBR; state_d = S_GAP; end
                           end
                           3'b001: thre_d = 1'b1;
                           3'b000: begin op_d = OP_MSR; state_d = S_GAP; end
                           default: ;
                        endcase
                     end
                  end
                  OP_LSR: begin lsrv_d = 1'b1; lsrd_d = rdata; end
                  OP_RBR: begin rxv_d = 1'b1; rxd_d = rdata; end
                  OP_MSR: begin msrv_d = 1'b1; msrd_d = rdata; end
                  default: txr_d = 1'b1;
               endcase
            end
         end
         default: begin
            state_d = S_SETUP;
            write_d = (op_q == OP_CFG);
            addr_d  = (op_q == OP_CFG) ? cfg_word[10:8] : rd_addr;
            wdata_d = (op_q == OP_CFG) ? cfg_word[7:0] : 8'h00;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= S_IDLE;  op_q <= OP_CFG;  step_q <= '0;  addr_q <= '0;
         wdata_q <= '0;  write_q <= 1'b0;  div_q <= '0;  lcr_q <= '0;  fcr_q <= '0;
         mcr_q <= '0;  ier_q <= '0;  busy_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;
         cfgd_q <= 1'b0;  txr_q <= 1'b0;  rxv_q <= 1'b0;  lsrv_q <= 1'b0;
         msrv_q <= 1'b0;  thre_q <= 1'b0;  slverr_q <= 1'b0;  rxd_q <= '0;
         lsrd_q <= '0;  msrd_q <= '0;
      end else begin
         state_q <= state_d;  op_q <= op_d;  step_q <= step_d;  addr_q <= addr_d;
         wdata_q <= wdata_d;  write_q <= write_d;  div_q <= div_d;  lcr_q <= lcr_d;
         fcr_q <= fcr_d;  mcr_q <= mcr_d;  ier_q <= ier_d;  busy_q <= busy_d;
         done_q <= done_d;  err_q <= err_d;  cfgd_q <= cfgd_d;  txr_q <= txr_d;
         rxv_q <= rxv_d;  lsrv_q <= lsrv_d;  msrv_q <= msrv_d;  thre_q <= thre_d;
         slverr_q <= slverr_d;  rxd_q <= rxd_d;  lsrd_q <= lsrd_d;  msrd_q <= msrd_d;
      end
   end

   assign apb.PSEL      = (state_q == S_SETUP) || (state_q == S_ACCESS);
   assign apb.PENABLE   = (state_q == S_ACCESS);
   assign apb.PWRITE    = write_q;
   assign apb.PADDR     = PADDR_WIDTH'(addr_q);
   assign apb.PWDATA    = PDATA_WIDTH'(wdata_q);
   assign cfg_busy      = busy_q;
   assign cfg_done      = done_q;
   assign cfg_err       = err_q;
   assign configured    = cfgd_q;
   assign tx_ready      = txr_q;
   assign rx_valid      = rxv_q;
   assign rx_data       = rxd_q;
   assign lsr_valid     = lsrv_q;
   assign lsr_data      = lsrd_q;
   assign msr_valid     = msrv_q;
   assign msr_data      = msrd_q;
   assign thre_event    = thre_q;
   assign slverr_sticky = slverr_q;
endmodule

// File: doc/uart_apb_service_ctrl.md
Name: uart_apb_service_ctrl

Overview:
APB master that owns the UART register port. On request it runs the UART programming sequence: divisor latch, line format, FIFO, MCR, IER. Afterwards it arbitrates the port between interrupt servicing (IIR-driven reads of LSR/RBR/MSR) and host transmit writes to THR. It sits between the system/host logic and the UART APB slave and is the only master on that bus.

Parameters:
PADDR_WIDTH, 8, APB address width; register offsets 0..7 zero-extended
PDATA_WIDTH, 8, APB data width; UART registers use bits [7:0], upper bits written 0

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  PADDR_WIDTH  register offset
PWDATA  out  PDATA_WIDTH  write data
PRDATA  in  PDATA_WIDTH  read data
PREADY  in  1  slave ready
PSLVERR  in  1  slave error
INTR  in  1  UART interrupt, level
cfg_start  in  1  start configuration, one-cycle pulse
cfg_divisor  in  16  baud divisor {DLM,DLL}
cfg_lcr  in  6  LCR[5:0] (word length, stop, parity)
cfg_fcr  in  8  FCR value
cfg_mcr  in  5  MCR[4:0]
cfg_ier  in  4  IER[3:0]
cfg_busy  out  1  configuration in progress
cfg_done  out  1  one-cycle pulse, sequence complete
cfg_err  out  1  one-cycle pulse, request rejected
configured  out  1  sticky, set at cfg_done
tx_valid  in  1  host byte available
tx_data  in  8  host byte
tx_ready  out  1  one-cycle pulse, THR write completed
rx_valid  out  1  rx_data holds unread byte
rx_data  out  8  last RBR byte
rx_ready  in  1  consumer accepts rx_data
lsr_valid / lsr_data  out  1 / 8  pulse plus LSR value read on RLS interrupt
msr_valid / msr_data  out  1 / 8  pulse plus MSR value read on modem interrupt
thre_event  out  1  pulse, THRE interrupt identified
slverr_sticky  out  1  any PSLVERR seen

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, FSM IDLE. An APB transfer in flight is abandoned and PSEL/PENABLE drop at once. configured is cleared only by reset.
- APB transfer: SETUP cycle (PSEL=1, PENABLE=0), then ACCESS (PSEL=1, PENABLE=1) held until PREADY=1.
  - PRDATA is sampled and PSLVERR is checked in the PREADY cycle.
  - PSEL=0 for at least one cycle between transfers.
  - Minimum 2 cycles per transfer plus 1 idle, i.e. 3 cycles per op.
  - PSLVERR=1 sets slverr_sticky; the sequence continues.
- Arbitration, evaluated only in IDLE, priority: cfg_start > service (INTR && configured) > tx (tx_valid && configured). No preemption once an operation starts.
- Config acceptance:
  - cfg_start in IDLE with cfg_divisor != 0 captures all cfg_* inputs and sets cfg_busy the next cycle.
  - cfg_divisor == 0: cfg_err pulses, nothing else happens.
  - cfg_start while not IDLE is ignored, no error.
- Config sequence, 7 writes in order:
  1. LCR(3) = {1,0,cfg_lcr}
  2. DLL(0) = div[7:0]
  3. DLM(1) = div[15:8]
  4. LCR(3) = {0,0,cfg_lcr}
  5. FCR(2) = cfg_fcr
  6. MCR(4) = {000,cfg_mcr}
  7. IER(1) = {0000,cfg_ier}
  - cfg_done pulses and cfg_busy drops in the cycle after the final write's PREADY. configured is set the same cycle. Total 21 cycles with PREADY always high.
  - Reconfiguration is allowed; configured stays 1 throughout.
- Service sequence: read IIR(2).
  - IIR[0]=1: return to IDLE.
  - IIR[3:1]=011: read LSR(5), then pulse lsr_valid with lsr_data.
  - IIR[3:1]=010 or 110:
    - If rx_valid=0: read RBR(0), then rx_valid=1 with rx_data.
    - If rx_valid=1: go to IDLE without reading. Service re-arbitrates while INTR stays high.
  - IIR[3:1]=001: pulse thre_event; the IIR read itself clears the source.
  - IIR[3:1]=000: read MSR(6), then pulse msr_valid with msr_data.
  - Any other code: return to IDLE.
- rx handshake: rx_valid && rx_ready clears rx_valid next cycle. Clear and a new RBR load never coincide, because the RBR read requires rx_valid=0.
- Tx: write THR(0) = tx_data, captured at grant. tx_ready pulses in the cycle after PREADY. Host must hold tx_valid/tx_data until tx_ready.
- Addresses are never written while DLAB=1 except DLL/DLM in config steps 2–3.

Test Plan:
- Config: div=0x0060, lcr=0x03, fcr=0xC7, mcr=0x03, ier=0x5, PREADY=1 → 7 writes in order (3:83, 0:60, 1:00, 3:03, 2:C7, 4:03, 1:05). cfg_done exactly 21 cycles after cfg_start; configured=1.
- cfg_start with div=0 → cfg_err pulse, no PSEL activity. Second cfg_start mid-sequence → ignored, sequence unchanged.
- INTR=1, IIR=0xC4 then RBR=0x5A → reads at addr 2 then 0, rx_valid=1, rx_data=0x5A. INTR still high with rx_ready=0 → IIR re-read, no RBR read until rx_ready.
- IIR=0xC6/LSR=0x61 → lsr_valid pulse with 0x61. IIR=0xC0/MSR=0xB0 → msr_valid with 0xB0. IIR=0xC2 → thre_event only. IIR=0xC1 → idle.
- PREADY low 3 cycles during DLL write → PENABLE held 4 cycles, addr/data stable. PSLVERR=1 there → slverr_sticky=1, sequence completes.
- tx_valid with INTR and cfg_start same cycle → config first, then service, then THR write. PRESETn low mid-ACCESS → PSEL/PENABLE 0 immediately, configured=0.
